// File: rtl/axis_instruction_replayer.sv
// axis_instruction_replayer
// Replays a block of instruction words from a single-port SRAM as AXI-Stream
// beats of {program_counter, instruction}. A small FIFO absorbs the one-cycle
// SRAM read latency so the stream sustains one beat per cycle under tready.
module axis_instruction_replayer #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [31:0] START_PC   = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  flush,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   length,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_read_enable,
   output logic                  mem_write_enable,
   input  logic [31:0]           mem_read_data,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic [31:0]           m_tdata_pc,
   output logic [31:0]           m_tdata_instr,
   output logic                  m_tlast
);

   localparam int unsigned        PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned        CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH:0] ONE_L  = (ADDR_WIDTH+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN
   } state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        last;
   } beat_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [ADDR_WIDTH:0]   len_q;
   logic [ADDR_WIDTH:0]   issued_q;
   logic [ADDR_WIDTH:0]   pushed_q;
   logic [ADDR_WIDTH:0]   last_idx;
   logic                  rd_pending_q;
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]      count_q;
   logic [CNT_W-1:0]      occupancy;
   logic                  done_q;
   logic                  rd_en, done_d;
   logic                  has_room, load, push, pop;
   beat_t                 fifo_mem [FIFO_DEPTH];
   beat_t                 head;

   // Index of the final word of the current replay (len_q >= 1 whenever it matters).
   assign last_idx  = len_q - ONE_L;
   // FIFO entries plus the read still in flight must never exceed the buffer size.
   assign occupancy = count_q + CNT_W'(rd_pending_q);
   assign has_room  = occupancy < DEPTH_C;
   assign load      = (state_q == S_IDLE) && start && !flush && (length != '0);
   assign push      = rd_pending_q;
   assign head      = fifo_mem[rd_ptr_q];
   assign m_tvalid  = (count_q != '0);
   assign pop       = m_tvalid && m_tready;

   assign busy             = (state_q != S_IDLE);
   assign done             = done_q;
   assign mem_read_enable  = rd_en;
   assign mem_address      = base_q + issued_q[ADDR_WIDTH-1:0];
   assign mem_write_enable = 1'b0;
   assign m_tdata_pc       = m_tvalid ? head.pc    : 32'h0;
   assign m_tdata_instr    = m_tvalid ? head.instr : 32'h0;
   assign m_tlast          = m_tvalid && head.last;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic, read issue and completion pulse; flush wins over everything.
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
      state_d = state_q;
      rd_en   = 1'b0;
      done_d  = 1'b0;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (length != '0) state_d = S_RUN;
                  else              done_d  = 1'b1;
               end
            end
            S_RUN: begin
               if (has_room) begin
                  rd_en = 1'b1;
                  if (issued_q == last_idx) state_d = S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (pop && head.last) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Replay bookkeeping, read tracking and FIFO pointers/occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base_q       <= '0;
         len_q        <= '0;
         issued_q     <= '0;
         pushed_q     <= '0;
         rd_pending_q <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         done_q       <= 1'b0;
      end else begin
         done_q <= done_d;
         if (flush) begin
            // Dropping rd_pending discards the SRAM word returning next cycle.
            rd_pending_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
         end else begin
            rd_pending_q <= rd_en;
            if (load) begin
               base_q   <= base_addr;
               len_q    <= length;
               issued_q <= '0;
               pushed_q <= '0;
            end
            if (rd_en) issued_q <= issued_q + ONE_L;
            if (push) begin
               wr_ptr_q <= wr_ptr_q + PTR_W'(1);
               pushed_q <= pushed_q + ONE_L;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (!push && pop) count_q <= count_q - CNT_W'(1);
         end
      end
   end

   // FIFO storage: capture the returning SRAM word with its pc and last flag.
   always_ff @(posedge clk) begin
      // NOTE: storage has no reset; stale entries are never visible because outputs are gated by m_tvalid.
      if (push && !flush) begin
         fifo_mem[wr_ptr_q] <= '{pc:    START_PC + 32'({pushed_q, 2'b00}),
                                 instr: mem_read_data,
                                 last:  (pushed_q == last_idx)};
      end
   end

endmodule

// File: tb/tb_axis_instruction_replayer.sv
// Testbench for axis_instruction_replayer: SRAM model plus a queue-based
// reference of the expected read addresses and beats for each replay.
module tb_axis_instruction_replayer;

   localparam int          AW    = 10;
   localparam int          DEPTH = 4;
   localparam int          MSIZE = 1 << AW;
   localparam logic [31:0] SPC   = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        last;
   } beat_t;

   logic          clk, rst, start, flush;
   logic [AW-1:0] base_addr;
   logic [AW:0]   length;
   logic          busy, done;
   logic [AW-1:0] mem_address;
   logic          mem_read_enable, mem_write_enable;
   logic [31:0]   mem_read_data;
   logic          m_tvalid, m_tready, m_tlast;
   logic [31:0]   m_tdata_pc, m_tdata_instr;

   logic [31:0]   sram [MSIZE];

   beat_t exp_q[$];
   int    addr_q[$];
   int    tests = 0, fails = 0;
   int    cyc_n = 0, reads_out = 0, done_cnt = 0, done_at = -1;
   int    first_valid = -1, first_read = -1;
   bit    prev_stall = 0;
   logic [63:0] prev_data;
   logic        prev_last;

   axis_instruction_replayer #(
      .ADDR_WIDTH(AW),
      .FIFO_DEPTH(DEPTH),
      .START_PC  (SPC)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .flush           (flush),
      .base_addr       (base_addr),
      .length          (length),
      .busy            (busy),
      .done            (done),
      .mem_address     (mem_address),
      .mem_read_enable (mem_read_enable),
      .mem_write_enable(mem_write_enable),
      .mem_read_data   (mem_read_data),
      .m_tvalid        (m_tvalid),
      .m_tready        (m_tready),
      .m_tdata_pc      (m_tdata_pc),
      .m_tdata_instr   (m_tdata_instr),
      .m_tlast         (m_tlast)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port SRAM with one-cycle read latency.
   always @(posedge clk) begin
      if (mem_read_enable) mem_read_data <= sram[mem_address];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
      tests++;
      assert (obs === want) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   // Expected reads and beats of one replay, straight from the addressing rules.
   task automatic load_expect(input int base, input int len);
      for (int k = 0; k < len; k++) begin
         int a;
         a = (base + k) % MSIZE;
         addr_q.push_back(a);
         exp_q.push_back('{pc: SPC + 32'(4 * k), instr: sram[a], last: (k == len - 1)});
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, then observe and score.
   task automatic cyc(input bit st, input bit fl, input bit rdy);
      beat_t b;
      @(negedge clk);
      start    = st;
      flush    = fl;
      m_tready = rdy;
      #1;
      cyc_n++;
      if (prev_stall) begin
         check("hold_valid", 64'(m_tvalid), 64'(1));
         check("hold_data", {m_tdata_pc, m_tdata_instr}, prev_data);
         check("hold_last", 64'(m_tlast), 64'(prev_last));
      end
      if (mem_read_enable === 1'b1) begin
         if (first_read < 0) first_read = cyc_n;
         if (addr_q.size() == 0) check("unexpected_read", 64'(1), 64'(0));
         else check("rd_addr", 64'(mem_address), 64'(addr_q.pop_front()));
         reads_out++;
         check("outstanding_le_depth", 64'(reads_out <= DEPTH), 64'(1));
         check("mem_we_zero", 64'(mem_write_enable), 64'(0));
      end
      if (m_tvalid === 1'b1 && first_valid < 0) first_valid = cyc_n;
      if (m_tvalid === 1'b1 && rdy) begin
         if (exp_q.size() == 0) check("unexpected_beat", 64'(1), 64'(0));
         else begin
            b = exp_q.pop_front();
            check("beat_pc", 64'(m_tdata_pc), 64'(b.pc));
            check("beat_instr", 64'(m_tdata_instr), 64'(b.instr));
            check("beat_last", 64'(m_tlast), 64'(b.last));
         end
         reads_out--;
      end
      if (done === 1'b1) begin
         done_cnt++;
         done_at = cyc_n;
      end
      prev_stall = (m_tvalid === 1'b1) && !rdy;
      prev_data  = {m_tdata_pc, m_tdata_instr};
      prev_last  = m_tlast;
      if (fl) begin
         exp_q.delete();
         addr_q.delete();
         reads_out  = 0;
         prev_stall = 0;
      end
   endtask

   // mode 0: tready=1, 1: tready 1,0,0 repeating, 2: random tready plus stray starts.
   // pre: start was already driven in the current (done) cycle by the previous call.
   // chain: after done, drive the next start in that same done cycle.
   task automatic run_replay(input int base, input int len, input int mode, input bit pre,
                             input bit chain, input int nb, input int nl);
      int s, i, budget;
      bit st, rdy;
      load_expect(base, len);
      first_valid = -1;
      first_read  = -1;
      done_cnt    = 0;
      if (!pre) begin
         base_addr = AW'(base);
         length    = (AW + 1)'(len);
         cyc(1'b1, 1'b0, 1'b1);
      end
      s      = cyc_n;
      budget = 4 * len + 50;
      i      = 0;
      while (done_cnt == 0 && i < budget) begin
         i++;
         st = 1'b0;
         if (mode == 2 && exp_q.size() > 1 && $urandom_range(0, 3) == 0) begin
            st        = 1'b1;
            base_addr = AW'($urandom);
            length    = (AW + 1)'($urandom_range(0, 2047));
         end
         if (mode == 0)      rdy = 1'b1;
         else if (mode == 1) rdy = (i % 3 == 1);
         else                rdy = bit'($urandom_range(0, 1));
         cyc(st, 1'b0, rdy);
         if (i == 1) check("busy_after_start", 64'(busy), 64'(1));
      end
      check("done_seen", 64'(done_cnt), 64'(1));
      check("beats_left", 64'(exp_q.size()), 64'(0));
      check("reads_left", 64'(addr_q.size()), 64'(0));
      check("busy_low_at_done", 64'(busy), 64'(0));
      if (mode == 0) begin
         check("read_latency", 64'(first_read - s), 64'(1));
         check("valid_latency", 64'(first_valid - s), 64'(3));
         check("done_latency", 64'(done_at - s), 64'(3 + len));
      end
      if (chain) begin
         base_addr = AW'(nb);
         length    = (AW + 1)'(nl);
         start     = 1'b1;
      end else begin
         cyc(1'b0, 1'b0, 1'b1);
         check("done_one_cycle", 64'(done), 64'(0));
      end
   endtask

   initial begin
      for (int a = 0; a < MSIZE; a++) sram[a] = $urandom;
      rst       = 1'b0;
      start     = 1'b0;
      flush     = 1'b0;
      m_tready  = 1'b0;
      base_addr = '0;
      length    = '0;
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_rd_en", 64'(mem_read_enable), 64'(0));
      check("rst_tvalid", 64'(m_tvalid), 64'(0));
      check("rst_tlast", 64'(m_tlast), 64'(0));
      check("rst_addr", 64'(mem_address), 64'(0));
      check("rst_tdata", {m_tdata_pc, m_tdata_instr}, 64'(0));
      rst = 1'b0;

      // Basic three-word replay with exact latency.
      run_replay(32'h010, 3, 0, 1'b0, 1'b0, 0, 0);
      // Backpressure pattern 1,0,0 with eight words.
      run_replay(32'h020, 8, 1, 1'b0, 1'b0, 0, 0);
      // Address wrap past the top of memory.
      run_replay(32'h3FE, 4, 0, 1'b0, 1'b0, 0, 0);

      // Zero-length start: only a done pulse.
      base_addr = AW'(5);
      length    = '0;
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      check("len0_done", 64'(done), 64'(1));
      check("len0_busy", 64'(busy), 64'(0));
      check("len0_rd_en", 64'(mem_read_enable), 64'(0));
      check("len0_tvalid", 64'(m_tvalid), 64'(0));
      cyc(1'b0, 1'b0, 1'b1);
      check("len0_done_drop", 64'(done), 64'(0));
      check("len0_busy_after", 64'(busy), 64'(0));

      // Flush two cycles after start while stalled, then replay from the first word.
      load_expect(32'h040, 8);
      base_addr = AW'(32'h040);
      length    = (AW + 1)'(8);
      done_cnt  = 0;
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      check("flush_tvalid", 64'(m_tvalid), 64'(0));
      check("flush_busy", 64'(busy), 64'(0));
      repeat (4) cyc(1'b0, 1'b0, 1'b1);
      check("flush_no_done", 64'(done_cnt), 64'(0));
      check("flush_still_idle", 64'(m_tvalid), 64'(0));
      run_replay(32'h040, 8, 0, 1'b0, 1'b0, 0, 0);

      // Reset mid-replay with beats pending.
      load_expect(32'h100, 8);
      base_addr = AW'(32'h100);
      length    = (AW + 1)'(8);
      cyc(1'b1, 1'b0, 1'b0);
      repeat (5) cyc(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_busy", 64'(busy), 64'(0));
      check("midrst_done", 64'(done), 64'(0));
      check("midrst_rd_en", 64'(mem_read_enable), 64'(0));
      check("midrst_tvalid", 64'(m_tvalid), 64'(0));
      check("midrst_tlast", 64'(m_tlast), 64'(0));
      check("midrst_addr", 64'(mem_address), 64'(0));
      check("midrst_tdata", {m_tdata_pc, m_tdata_instr}, 64'(0));
      exp_q.delete();
      addr_q.delete();
      reads_out  = 0;
      prev_stall = 0;
      @(negedge clk);
      rst = 1'b0;
      run_replay(32'h100, 8, 0, 1'b0, 1'b0, 0, 0);

      // Start accepted in the same cycle as done.
      run_replay(32'h200, 5, 0, 1'b0, 1'b1, 32'h300, 6);
      run_replay(32'h300, 6, 0, 1'b1, 1'b0, 0, 0);

      // Maximum length covering the whole memory.
      run_replay(32'h155, MSIZE, 0, 1'b0, 1'b0, 0, 0);

      // Random replays with random backpressure and ignored starts while busy.
      for (int r = 0; r < 8; r++) begin
         run_replay(int'($urandom_range(0, MSIZE - 1)), int'($urandom_range(1, 24)), 2,
                    1'b0, 1'b0, 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
